// File: rtl/mmio_pkg.sv
// Shared constants for the Tetris MMIO bridge: register offsets within the
// MMIO window, keyboard event codes, and the tick-counter saturation limit.
package mmio_pkg;

  localparam int unsigned REG_KEY_POP  = 0;
  localparam int unsigned REG_KEY_STAT = 1;
  localparam int unsigned REG_TICK     = 2;
  localparam int unsigned REG_SCORE    = 3;
  localparam int unsigned REG_LED      = 4;

  localparam int unsigned KEY_W    = 3;
  localparam int unsigned TICK_W   = 8;
  localparam int unsigned LED_W    = 8;
  localparam int unsigned TICK_SAT = 255;

  typedef enum logic [KEY_W-1:0] {
    KEY_NONE      = 3'd0,
    KEY_LEFT      = 3'd1,
    KEY_RIGHT     = 3'd2,
    KEY_ROTATE    = 3'd3,
    KEY_HARD_DROP = 3'd4,
    KEY_SOFT_DROP = 3'd5,
    KEY_PAUSE     = 3'd6
  } key_code_e;

endpackage

// File: rtl/mmio_bridge_sync_fifo.sv
// Small synchronous FIFO with registered pointers and occupancy count.
// Pops on empty are ignored; a push while full is accepted only with a pop.
module sync_fifo #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides validity.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mmio_bridge.sv
// Data-memory bridge: plain loads/stores go to dmem, the window at MMIO_BASE
// and above maps the key FIFO, game tick counter, score and LED registers.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 8,
  parameter int                TICK_DIV   = 1000000,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 12'hF00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] proc_address,
  input  logic [DATA_W-1:0] proc_data,
  input  logic              proc_wren,
  input  logic              proc_rden,
  output logic [DATA_W-1:0] proc_q,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  output logic [DATA_W-1:0] score_out,
  output logic [LED_W-1:0]  led_out,
  output logic              fifo_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic              mmio_sel;
  logic [ADDR_W-1:0] offset;
  logic              pop_req, stat_rd, tick_wr, score_wr, led_wr;
  logic [DATA_W-1:0] mmio_rdata;

  logic [KEY_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, key_drop;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_wrap;
  logic [TICK_W-1:0] pending_q, pending_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] score_q, score_d;
  logic [LED_W-1:0]  led_q, led_d;

  assign mmio_sel = (proc_address >= MMIO_BASE);
  assign offset   = proc_address - MMIO_BASE;

  assign dmem_address = proc_address;
  assign dmem_data    = proc_data;
  assign dmem_wren    = proc_wren & ~mmio_sel;
  assign proc_q       = mmio_sel ? mmio_rdata : dmem_q;

  assign pop_req  = mmio_sel & proc_rden & (offset == ADDR_W'(REG_KEY_POP));
  assign stat_rd  = mmio_sel & proc_rden & (offset == ADDR_W'(REG_KEY_STAT));
  assign tick_wr  = mmio_sel & proc_wren & (offset == ADDR_W'(REG_TICK));
  assign score_wr = mmio_sel & proc_wren & (offset == ADDR_W'(REG_SCORE));
  assign led_wr   = mmio_sel & proc_wren & (offset == ADDR_W'(REG_LED));

  sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (key_valid),
    .pop_i   (pop_req),
    .data_i  (key_code),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A full FIFO is never empty, so a pop request there always frees a slot.
  assign key_drop  = key_valid & fifo_full & ~pop_req;
  assign tick_wrap = (div_q == DIV_W'(TICK_DIV - 1));

  always_comb begin
    div_d     = tick_wrap ? '0 : div_q + DIV_W'(1);
    pending_d = pending_q;
    if (tick_wr)
      pending_d = TICK_W'(tick_wrap);
    else if (tick_wrap && pending_q != TICK_W'(TICK_SAT))
      pending_d = pending_q + TICK_W'(1);

    ovf_d = ovf_q;
    if (stat_rd)  ovf_d = 1'b0;
    if (key_drop) ovf_d = 1'b1;

    score_d = score_wr ? proc_data : score_q;
    led_d   = led_wr ? proc_data[LED_W-1:0] : led_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      score_q   <= '0;
      led_q     <= '0;
    end else begin
      div_q     <= div_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      score_q   <= score_d;
      led_q     <= led_d;
    end
  end

  // Read data comes straight from pre-edge state, same cycle as the address.
  always_comb begin
    mmio_rdata = '0;
    case (offset)
      ADDR_W'(REG_KEY_POP): begin
        if (!fifo_empty) begin
          mmio_rdata[DATA_W-1]  = 1'b1;
          mmio_rdata[KEY_W-1:0] = fifo_head;
        end
      end
      ADDR_W'(REG_KEY_STAT): begin
        mmio_rdata[DATA_W-1]  = ovf_q;
        mmio_rdata[CNT_W-1:0] = fifo_count;
      end
      ADDR_W'(REG_TICK):  mmio_rdata[TICK_W-1:0] = pending_q;
      ADDR_W'(REG_SCORE): mmio_rdata = score_q;
      ADDR_W'(REG_LED):   mmio_rdata[LED_W-1:0] = led_q;
      default:            mmio_rdata = '0;
    endcase
  end

  assign score_out     = score_q;
  assign led_out       = led_q;
  assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Randomised and directed checks of mmio_bridge against a queue-based model
// of the register map, key FIFO and tick counter.
module tb_mmio_bridge;
  import mmio_pkg::*;

  localparam int TDIV  = 4;
  localparam int DEPTH = 8;
  localparam logic [11:0] BASE = 12'hF00;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] proc_address;
  logic [31:0] proc_data;
  logic        proc_wren, proc_rden;
  logic [31:0] proc_q;
  logic [11:0] dmem_address;
  logic [31:0] dmem_data;
  logic        dmem_wren;
  logic [31:0] dmem_q;
  logic        key_valid;
  logic [2:0]  key_code;
  logic [31:0] score_out;
  logic [7:0]  led_out;
  logic        fifo_overflow;

  always #5 clock = ~clock;

  mmio_bridge #(
    .ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(DEPTH), .TICK_DIV(TDIV), .MMIO_BASE(BASE)
  ) dut (
    .clock(clock), .reset(reset),
    .proc_address(proc_address), .proc_data(proc_data),
    .proc_wren(proc_wren), .proc_rden(proc_rden), .proc_q(proc_q),
    .dmem_address(dmem_address), .dmem_data(dmem_data),
    .dmem_wren(dmem_wren), .dmem_q(dmem_q),
    .key_valid(key_valid), .key_code(key_code),
    .score_out(score_out), .led_out(led_out), .fifo_overflow(fifo_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [2:0]  m_fifo[$];
  bit          m_ovf;
  int          m_pend;
  logic [31:0] m_score;
  logic [7:0]  m_led;
  int          m_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [11:0] off;
    logic [3:0]  sz;
    if (a < BASE) return dmem_q;
    off = a - BASE;
    sz  = 4'(m_fifo.size());
    case (off)
      12'd0:   return (m_fifo.size() > 0) ? {1'b1, 28'b0, m_fifo[0]} : 32'h0;
      12'd1:   return {m_ovf, 27'b0, sz};
      12'd2:   return 32'(m_pend);
      12'd3:   return m_score;
      12'd4:   return {24'b0, m_led};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic [11:0] a, input logic [31:0] d,
                       input logic wr, input logic rd, input logic kv, input logic [2:0] kc);
    reset        = rst;
    proc_address = a;
    proc_data    = d;
    proc_wren    = wr;
    proc_rden    = rd;
    key_valid    = kv;
    key_code     = kc;
    dmem_q       = $urandom;
    #1;
  endtask

  // Apply the rules for the coming rising edge to the model, then take the edge.
  task automatic commit();
    bit sel, popped, wrap, full;
    logic [11:0] off;
    sel = (proc_address >= BASE);
    off = proc_address - BASE;
    if (reset) begin
      m_fifo.delete();
      m_ovf = 0; m_pend = 0; m_score = 0; m_led = 0; m_cyc = 0;
    end else begin
      full   = (m_fifo.size() == DEPTH);
      popped = sel && proc_rden && off == 0 && m_fifo.size() > 0;
      if (sel && proc_rden && off == 1) m_ovf = 0;
      if (popped) void'(m_fifo.pop_front());
      if (key_valid) begin
        if (!full || popped) m_fifo.push_back(key_code);
        else m_ovf = 1;
      end
      wrap = (m_cyc % TDIV) == TDIV - 1;
      m_cyc++;
      if (sel && proc_wren && off == 2) m_pend = wrap ? 1 : 0;
      else if (wrap && m_pend < 255) m_pend++;
      if (sel && proc_wren && off == 3) m_score = proc_data;
      if (sel && proc_wren && off == 4) m_led = proc_data[7:0];
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 12'h000, 32'h0, 0, 0, 0, 3'd0);
      commit();
    end
  endtask

  task automatic rd(input logic [11:0] a, input string tag);
    drive(0, a, $urandom, 0, 1, 0, 3'd0);
    check(tag, proc_q, m_read(a));
    commit();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input string tag);
    drive(0, a, d, 1, 0, 0, 3'd0);
    check({tag, "_wren"}, 32'(dmem_wren), 32'(a < BASE));
    commit();
  endtask

  task automatic push(input logic [2:0] c);
    drive(0, 12'h000, 32'h0, 0, 0, 1, c);
    commit();
  endtask

  initial begin
    m_ovf = 0; m_pend = 0; m_score = 0; m_led = 0; m_cyc = 0;
    drive(1, 12'h000, 32'h0, 0, 0, 0, 3'd0);
    commit();
    commit();

    // Reset state
    drive(0, BASE + 12'd1, 32'h0, 0, 0, 0, 3'd0);
    check("rst_stat", proc_q, 32'h0);
    check("rst_score", score_out, 32'h0);
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_ovf", 32'(fifo_overflow), 32'h0);
    commit();

    // Pass-through
    drive(0, 12'h010, 32'hDEADBEEF, 1, 0, 0, 3'd0);
    check("pt_wren", 32'(dmem_wren), 32'h1);
    check("pt_addr", 32'(dmem_address), 32'h010);
    check("pt_data", dmem_data, 32'hDEADBEEF);
    commit();
    drive(0, 12'h010, 32'h0, 0, 1, 0, 3'd0);
    check("pt_rdata", proc_q, dmem_q);
    check("pt_score", score_out, 32'h0);
    commit();

    // Basic FIFO order and empty read
    push(KEY_LEFT); push(KEY_RIGHT); push(KEY_ROTATE);
    drive(0, BASE, 32'h0, 0, 1, 0, 3'd0); check("pop1", proc_q, 32'h80000001); commit();
    drive(0, BASE, 32'h0, 0, 1, 0, 3'd0); check("pop2", proc_q, 32'h80000002); commit();
    drive(0, BASE, 32'h0, 0, 1, 0, 3'd0); check("pop3", proc_q, 32'h80000003); commit();
    drive(0, BASE, 32'h0, 0, 1, 0, 3'd0); check("pop_empty", proc_q, 32'h0); commit();
    drive(0, BASE + 12'd1, 32'h0, 0, 1, 0, 3'd0); check("stat_empty", proc_q, 32'h0); commit();

    // Push and pop together while empty: read sees 0, event is kept
    drive(0, BASE, 32'h0, 0, 1, 1, KEY_SOFT_DROP);
    check("pp_empty_rd", proc_q, 32'h0);
    commit();
    drive(0, BASE, 32'h0, 0, 1, 0, 3'd0); check("pp_empty_kept", proc_q, 32'h80000005); commit();

    // Overflow
    for (int i = 0; i < 9; i++) push(3'($urandom_range(1, 6)));
    check("ovf_flag", 32'(fifo_overflow), 32'h1);
    drive(0, BASE + 12'd1, 32'h0, 0, 1, 0, 3'd0); check("stat_ovf", proc_q, 32'h80000008); commit();
    drive(0, BASE + 12'd1, 32'h0, 0, 1, 0, 3'd0); check("stat_clr", proc_q, 32'h00000008); commit();
    // Push and pop together while full: both happen, no overflow
    drive(0, BASE, 32'h0, 0, 1, 1, KEY_PAUSE);
    check("pp_full_rd", proc_q, m_read(BASE));
    commit();
    rd(BASE + 12'd1, "pp_full_stat");
    for (int i = 0; i < 8; i++) rd(BASE, "ovf_order");
    rd(BASE, "ovf_drained");

    // Tick counter
    wr(BASE + 12'd2, 32'h0, "tick_clr");
    idle(40);
    rd(BASE + 12'd2, "tick_40");
    while ((m_cyc % TDIV) != TDIV - 1) idle(1);
    wr(BASE + 12'd2, 32'h0, "tick_wrapwr");
    drive(0, BASE + 12'd2, 32'h0, 0, 1, 0, 3'd0); check("tick_wrap1", proc_q, 32'h1); commit();
    idle(1100);
    drive(0, BASE + 12'd2, 32'h0, 0, 1, 0, 3'd0); check("tick_sat", proc_q, 32'd255); commit();

    // Score / LED / unmapped
    wr(BASE + 12'd3, 32'h00000064, "score");
    wr(BASE + 12'd4, 32'h000001FF, "led");
    check("score_out", score_out, 32'd100);
    check("led_out", 32'(led_out), 32'hFF);
    rd(BASE + 12'd3, "score_rd");
    rd(BASE + 12'd4, "led_rd");
    drive(0, BASE + 12'h10, 32'h0, 0, 1, 0, 3'd0); check("unmapped", proc_q, 32'h0); commit();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [11:0] a;
      logic w;
      r = $urandom_range(0, 9);
      if (r <= 6)      a = BASE + 12'(r);
      else if (r == 7) a = BASE + 12'h10;
      else if (r == 8) a = 12'($urandom_range(0, 12'hEFF));
      else             a = 12'hFFF;
      w = ($urandom_range(0, 3) == 0);
      drive(0, a, $urandom, w, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, 3'($urandom_range(0, 6)));
      check("rnd_q", proc_q, m_read(a));
      check("rnd_wren", 32'(dmem_wren), 32'(w && a < BASE));
      commit();
      check("rnd_score", score_out, m_score);
      check("rnd_led", 32'(led_out), 32'(m_led));
      check("rnd_ovf", 32'(fifo_overflow), 32'(m_ovf));
    end

    // Reset mid-operation
    for (int i = 0; i < 10; i++) push(KEY_HARD_DROP);
    wr(BASE + 12'd3, 32'h12345678, "pre_rst_score");
    wr(BASE + 12'd4, 32'h000000A5, "pre_rst_led");
    idle(8);
    drive(1, 12'h000, 32'h0, 0, 0, 0, 3'd0);
    commit();
    drive(0, BASE + 12'd1, 32'h0, 0, 0, 0, 3'd0); check("mr_stat", proc_q, 32'h0); commit();
    drive(0, BASE + 12'd2, 32'h0, 0, 0, 0, 3'd0); check("mr_tick", proc_q, 32'h0);
    check("mr_score", score_out, 32'h0);
    check("mr_led", 32'(led_out), 32'h0);
    check("mr_ovf", 32'(fifo_overflow), 32'h0);
    commit();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits between the processor's data-memory port and dmem.
- Passes ordinary loads and stores through to dmem.
- Decodes a high address window into memory-mapped game I/O:
  - a key-event FIFO, fed by the upstream keyboard decoder,
  - a game-tick counter,
  - score and LED output registers.
- Lets Tetris software poll input and timing with plain lw/sw.

Parameters:
- ADDR_W, 12, dmem/processor address width
- DATA_W, 32, data width
- FIFO_DEPTH, 8, key-event FIFO entries (power of two)
- TICK_DIV, 1000000, clock cycles per game tick
- MMIO_BASE, 12'hF00, first MMIO address; addresses >= MMIO_BASE never reach dmem

Ports:
- clock  in  1  master clock (same clock as processor)
- reset  in  1  synchronous, active-high reset
- proc_address  in  12  processor dmem address
- proc_data  in  32  processor store data
- proc_wren  in  1  processor store strobe
- proc_rden  in  1  processor load strobe (asserted for lw)
- proc_q  out  32  load data returned to processor
- dmem_address  out  12  to dmem
- dmem_data  out  32  to dmem
- dmem_wren  out  1  to dmem
- dmem_q  in  32  from dmem
- key_valid  in  1  one-cycle key event strobe
- key_code  in  3  event code (see package)
- score_out  out  32  SCORE register to display logic
- led_out  out  8  LED register
- fifo_overflow  out  1  sticky overflow flag

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`. On reset:
  - FIFO empties.
  - Tick divider, pending count, score_out, led_out and fifo_overflow all go to 0.
- Decode: mmio_sel = (proc_address >= MMIO_BASE).
- Pass-through:
  - dmem_address and dmem_data always equal proc_address and proc_data.
  - dmem_wren = proc_wren & ~mmio_sel.
  - proc_q = dmem_q when ~mmio_sel.
- Register map (offset from MMIO_BASE):
  - 0 KEY_POP (read):
    - Returns {31'b0? no: bit31=nonempty, bits30:3=0, bits2:0=head code}.
    - When empty, returns 0.
    - A read (proc_rden & sel) pops the head at the next rising edge.
  - 1 KEY_STAT (read):
    - bit31 = overflow, bits3:0 = occupancy.
    - A read clears overflow at the next rising edge.
  - 2 TICK (R/W):
    - Read returns the pending tick count, 8-bit zero-extended.
    - Any write clears it.
  - 3 SCORE (R/W): full 32 bits; drives score_out.
  - 4 LED (R/W): bits7:0; drives led_out. Reads return zero-extended.
  - 5..end: reads return 0; writes are ignored.
- MMIO read data is combinational from current register state. It is valid in the same cycle as the address, matching dmem's inverted-clock read timing.
- All MMIO writes and side effects commit on the rising edge of `clock`.
- FIFO:
  - key_valid pushes key_code.
  - Push while full (with no pop that cycle): the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both occur, and occupancy stays at FIFO_DEPTH.
  - Push and pop in the same cycle while empty: the push is stored. The read returns 0, because head data comes from pre-edge state.
  - Pop while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow set and clear in the same cycle: set wins.
- Tick:
  - The divider counts 0..TICK_DIV-1 and wraps.
  - On each wrap, pending increments, saturating at 255.
  - A write to TICK in the same cycle as a wrap leaves pending = 1.
- Reset asserted mid-operation discards FIFO contents and pending ticks. dmem contents are unaffected.

Decomposition:
- Package mmio_pkg holds:
  - register offsets (KEY_POP=0, KEY_STAT=1, TICK=2, SCORE=3, LED=4),
  - key codes (NONE=0, LEFT=1, RIGHT=2, ROTATE=3, HARD_DROP=4, SOFT_DROP=5, PAUSE=6),
  - TICK_SAT=255.
- One sub-module: sync_fifo, parameterised on width and depth, with push, pop, head, count and full/empty outputs.

Test Plan:
- Reset, then proc_address=0x010, proc_wren=1, data=0xDEADBEEF -> dmem_wren=1 with the same address and data. A following read of 0x010 returns dmem_q unchanged. score_out=0.
- Push codes 1,2,3, then read 0xF00 three times -> 0x80000001, 0x80000002, 0x80000003. A fourth read -> 0x00000000. KEY_STAT=0.
- Push 9 events at FIFO_DEPTH=8 -> KEY_STAT=0x80000008 and fifo_overflow=1. Read STAT again -> 0x00000008. Popped order matches the first 8 pushes.
- TICK_DIV=4, run 40 cycles -> TICK reads 10. Write TICK on a wrap cycle -> reads 1. Run 1100 cycles without clearing -> saturates at 255.
- sw 0x00000064 to 0xF03 and 0x1FF to 0xF04 -> score_out=100, led_out=0xFF, dmem_wren=0 on both. Read 0xF10 -> 0.
- Fill FIFO, assert reset for 1 cycle mid-sequence -> KEY_STAT=0, TICK=0, score_out=0, led_out=0, fifo_overflow=0.
